// File: rtl/rx_iq_serializer.sv
// RX IQ stream serializer: pulls samples from usiq_fifo through a one-entry prefetch buffer
// and hands them out MSB-first as OUT_W-bit words, one word per read strobe.
module rx_iq_serializer #(
    parameter int unsigned NR        = 1,
    parameter int unsigned SAMPLE_W  = 24,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned LEN_W     = 11,
    parameter int unsigned THRESH    = 256,
    parameter bit          HDR_EN    = 1'b0,
    parameter int unsigned SYNC_WORD = 32'hA5,
    parameter int unsigned IDLE_WORD = 32'h0
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [SAMPLE_W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    input  logic [LEN_W-1:0]    fifo_level,
    input  logic                rd_strobe,
    input  logic                clr_status,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_frame_start,
    output logic                o_avail,
    output logic                underrun,
    output logic                sync_err
);

    localparam int unsigned W      = SAMPLE_W / OUT_W;
    localparam int unsigned GRP    = 2 * NR;
    localparam int unsigned WIDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SIDX_W = $clog2(GRP);

    localparam logic [OUT_W-1:0]  SYNC      = OUT_W'(SYNC_WORD);
    localparam logic [OUT_W-1:0]  IDLE      = OUT_W'(IDLE_WORD);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(W - 1);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(GRP - 1);
    localparam logic [LEN_W-1:0]  THR       = LEN_W'(THRESH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HDR   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic                pf_empty;
    logic [SAMPLE_W-1:0] pf_data;
    logic                pf_last;
    logic [SAMPLE_W-1:0] sreg;
    logic [SAMPLE_W-1:0] sreg_shl;
    logic                sreg_last;
    logic [WIDX_W-1:0]   widx;
    logic [SIDX_W-1:0]   sidx;
    logic                hdr_pend;
    logic                xfer;

    logic                at_bound;
    logic                mid_word;
    logic [SIDX_W-1:0]   sidx_adv;
    logic [SIDX_W-1:0]   sidx_eff;
    logic                hdr_eff;

    logic [OUT_W-1:0]    o_data_n;
    logic                frame_n;
    logic [SAMPLE_W-1:0] sreg_n;
    logic                sreg_last_n;
    logic [WIDX_W-1:0]   widx_n;
    logic [SIDX_W-1:0]   sidx_n;
    logic                hdr_n;
    logic                consume;
    logic                set_und;
    logic                set_serr;

    assign s_tready = pf_empty;
    assign xfer     = s_tvalid & pf_empty;
    assign sreg_shl = sreg << OUT_W;

    // Group position as seen by this strobe: a sample boundary advances sidx before loading.
    always_comb begin
        at_bound = (state == ST_SHIFT) && (widx == WIDX_LAST);
        mid_word = (state == ST_SHIFT) && !at_bound;
        sidx_adv = (sreg_last || (sidx == SIDX_LAST)) ? '0 : sidx + SIDX_W'(1);
        sidx_eff = at_bound ? sidx_adv : sidx;
        hdr_eff  = at_bound ? (HDR_EN && (sidx_adv == '0)) : hdr_pend;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (rd_strobe && !mid_word) begin
            if (hdr_eff) begin
                state_n = ST_HDR;
            end else if (!pf_empty) begin
                state_n = ST_SHIFT;
            end else if (state == ST_HDR) begin
                state_n = ST_HDR;
            end else begin
                state_n = ST_EMPTY;
            end
        end
    end

    always_comb begin
        o_data_n    = o_data;
        frame_n     = o_frame_start;
        sreg_n      = sreg;
        sreg_last_n = sreg_last;
        widx_n      = widx;
        sidx_n      = sidx;
        hdr_n       = hdr_pend;
        consume     = 1'b0;
        set_und     = 1'b0;
        set_serr    = 1'b0;
        if (rd_strobe) begin
            if (mid_word) begin
                widx_n   = widx + WIDX_W'(1);
                sreg_n   = sreg_shl;
                o_data_n = sreg_shl[SAMPLE_W-1 -: OUT_W];
                frame_n  = 1'b0;
            end else begin
                sidx_n = sidx_eff;
                if (hdr_eff) begin
                    o_data_n = SYNC;
                    frame_n  = 1'b1;
                    hdr_n    = 1'b0;
                end else if (!pf_empty) begin
                    sreg_n      = pf_data;
                    sreg_last_n = pf_last;
                    o_data_n    = pf_data[SAMPLE_W-1 -: OUT_W];
                    widx_n      = '0;
                    consume     = 1'b1;
                    frame_n     = (state != ST_HDR) && (sidx_eff == '0);
                    set_serr    = (sidx_eff == SIDX_LAST) != pf_last;
                end else begin
                    // Position is held so the next strobe retries the same boundary.
                    o_data_n = IDLE;
                    frame_n  = 1'b0;
                    set_und  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            pf_empty      <= 1'b1;
            pf_data       <= '0;
            pf_last       <= 1'b0;
            sreg          <= '0;
            sreg_last     <= 1'b0;
            widx          <= '0;
            sidx          <= '0;
            hdr_pend      <= HDR_EN;
            o_data        <= IDLE;
            o_frame_start <= 1'b0;
            o_avail       <= 1'b0;
            underrun      <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            if (xfer) begin
                pf_data <= s_tdata;
                pf_last <= s_tlast;
            end
            pf_empty      <= xfer ? 1'b0 : (consume ? 1'b1 : pf_empty);
            sreg          <= sreg_n;
            sreg_last     <= sreg_last_n;
            widx          <= widx_n;
            sidx          <= sidx_n;
            hdr_pend      <= hdr_n;
            o_data        <= o_data_n;
            o_frame_start <= frame_n;
            o_avail       <= fifo_level > THR;
            // A new event outranks a coincident clear.
            underrun      <= set_und | (underrun & ~clr_status);
            sync_err      <= set_serr | (sync_err & ~clr_status);
        end
    end

endmodule
